// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Definitions shared by the cpu, the instruction memory and
//                the boot-time program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    // Instruction word width; three stream bytes carry one word
    localparam int INSTR_WIDTH  = 18;
    localparam int OPCODE_WIDTH = 4;

    // Loader state encoding
    localparam logic [3:0] LD_IDLE   = 4'd0;
    localparam logic [3:0] LD_LEN_HI = 4'd1;
    localparam logic [3:0] LD_LEN_LO = 4'd2;
    localparam logic [3:0] LD_B0     = 4'd3;
    localparam logic [3:0] LD_B1     = 4'd4;
    localparam logic [3:0] LD_B2     = 4'd5;
    localparam logic [3:0] LD_WRITE  = 4'd6;
    localparam logic [3:0] LD_DONE   = 4'd7;
    localparam logic [3:0] LD_ERR    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE   = LD_IDLE,
        S_LEN_HI = LD_LEN_HI,
        S_LEN_LO = LD_LEN_LO,
        S_B0     = LD_B0,
        S_B1     = LD_B1,
        S_B2     = LD_B2,
        S_WRITE  = LD_WRITE,
        S_DONE   = LD_DONE,
        S_ERR    = LD_ERR
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Boot-time loader. Parses a length-prefixed byte stream,
//                assembles 18-bit words and writes them to instruction
//                memory from address 0, holding the cpu in reset until done.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int INSTR_WIDTH = 18,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);
    import cpu_defs::*;

    // Largest legal word count: the image may fill the memory exactly
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    ld_state_t   state;
    ld_state_t   state_nxt;
    logic [15:0] shift_reg;     // LEN_HI during length parse, B1 during word parse
    logic [1:0]  b0_bits;       // low two bits of B0
    logic [15:0] word_count;    // N
    logic [15:0] word_idx;      // index of the word being assembled
    logic [15:0] len_now;       // N as seen on the LEN_LO beat
    logic        beat;
    logic        start_ok;

    assign beat     = in_valid & in_ready;
    assign len_now  = {shift_reg[7:0], in_byte};
    assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_now == 16'd0)                 state_nxt = S_DONE;
                    else if (32'(len_now) > MAX_WORDS)    state_nxt = S_ERR;
                    else                                  state_nxt = S_B0;
                end
            end
            S_B0: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_byte[7:2] != 6'd0) ? S_ERR : S_B1;
            end
            S_B1: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_B2;
            end
            S_B2: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                imem_we   = 1'b1;
                state_nxt = ((word_idx + 16'd1) == word_count) ? S_DONE : S_B0;
            end
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nxt = S_LEN_HI;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte capture, word assembly, write address/data and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= 16'd0;
            b0_bits    <= 2'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (start_ok) begin
                word_idx  <= 16'd0;
                imem_addr <= '0;
            end
            if (beat) begin
                case (state)
                    S_LEN_HI: shift_reg  <= {shift_reg[7:0], in_byte};
                    S_LEN_LO: word_count <= len_now;
                    S_B0:     b0_bits    <= in_byte[1:0];
                    S_B1:     shift_reg  <= {shift_reg[7:0], in_byte};
                    S_B2: begin
                        imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= {b0_bits, shift_reg[7:0], in_byte};
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader with randomized
//                valid gaps and a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 8;
    localparam int IW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    logic [7:0]       stim[$];
    logic [AW+IW-1:0] exp_wr[$];
    logic [AW+IW-1:0] obs_wr[$];
    logic             exp_done;
    logic             exp_err;

    program_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Record every memory write; the loader must never offer ready while writing
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            obs_wr.push_back({imem_addr, imem_wdata});
            chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    // Reference model: interpret the stream as length + words
    function automatic void model();
        int n;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = (int'(stim[0]) << 8) | int'(stim[1]);
        if (n == 0) begin
            exp_done = 1'b1;
        end else if (n > (1 << AW)) begin
            exp_err = 1'b1;
        end else begin
            exp_done = 1'b1;
            for (int w = 0; w < n; w++) begin
                int b0, b1, b2;
                b0 = int'(stim[2 + 3*w]);
                if (b0 > 3) begin
                    exp_err  = 1'b1;
                    exp_done = 1'b0;
                    break;
                end
                b1 = int'(stim[3 + 3*w]);
                b2 = int'(stim[4 + 3*w]);
                exp_wr.push_back({w[AW-1:0], 18'((b0 << 16) + (b1 << 8) + b2)});
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Deliver stim[first..last] with random idle gaps (gap_pct percent)
    task automatic send(input int first, input int last, input int gap_pct);
        int idx    = first;
        int budget = 10 * (last - first + 1) + 50;
        int cyc    = 0;
        while (idx <= last && cyc < budget) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= gap_pct);
            in_byte  = in_valid ? stim[idx] : 8'($urandom);
            #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (idx <= last) chk("send_timeout", idx, last + 1);
    endtask

    task automatic wait_end();
        int cyc = 0;
        while (!(done || error) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk({tag, "_wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
        chk({tag, "_done"},  {31'd0, done},      {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error},     {31'd0, exp_err});
        chk({tag, "_cpurst"}, {31'd0, cpu_reset}, {31'd0, ~exp_done});
    endtask

    task automatic run_image(input string tag, input int gap_pct);
        model();
        obs_wr.delete();
        pulse_start();
        send(0, stim.size() - 1, gap_pct);
        wait_end();
        repeat (2) @(negedge clk);
        compare(tag);
    endtask

    task automatic push_word(input logic [17:0] w);
        stim.push_back({6'd0, w[17:16]});
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    task automatic load_t2_image();
        stim = '{8'h00, 8'h07};
        push_word(18'h08004); push_word(18'h24000); push_word(18'h20400);
        push_word(18'h04840); push_word(18'h24801); push_word(18'h0c081);
        push_word(18'h24c00);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready},  32'd0);
        chk("rst_we",       {31'd0, imem_we},   32'd0);
        chk("rst_addr",     32'(imem_addr),     32'd0);
        chk("rst_wdata",    32'(imem_wdata),    32'd0);
        chk("rst_cpurst",   {31'd0, cpu_reset}, 32'd1);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_error",    {31'd0, error},     32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word, known data
        stim = '{8'h00, 8'h01, 8'h00, 8'h80, 8'h04};
        run_image("t1", 0);
        if (obs_wr.size() > 0) chk("t1_data", 32'(obs_wr[0]), {6'd0, 8'h00, 18'h08004});

        // Seven-word image, back-to-back then with gaps
        load_t2_image();
        run_image("t2", 0);
        load_t2_image();
        run_image("t3", 50);

        // Empty image and oversize image
        stim = '{8'h00, 8'h00};
        run_image("t4_zero", 30);
        stim = '{8'h01, 8'h01};
        run_image("t4_big", 30);

        // Image that fills memory exactly
        stim = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) push_word(18'($urandom));
        run_image("full", 10);

        // Bad B0 in second word, then recovery with a valid image
        stim = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h04};
        run_image("t5_err", 20);
        load_t2_image();
        run_image("t5_recover", 20);

        // Random images, occasionally malformed
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 12);
            stim = '{8'h00, 8'(n)};
            for (int w = 0; w < n; w++) begin
                logic [7:0] b0;
                b0 = ($urandom_range(9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(3));
                stim.push_back(b0);
                if (b0 > 8'd3) break;
                stim.push_back(8'($urandom));
                stim.push_back(8'($urandom));
            end
            run_image("rand", $urandom_range(60));
        end

        // Reset after two of three words
        stim = '{8'h00, 8'h03};
        push_word(18'h1abcd); push_word(18'h2f00f); push_word(18'h00001);
        obs_wr.delete();
        pulse_start();
        send(0, 7, 0);
        repeat (2) @(negedge clk);
        chk("t6_two_writes", obs_wr.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_ready",  {31'd0, in_ready},  32'd0);
        chk("t6_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("t6_addr",   32'(imem_addr),     32'd0);
        chk("t6_done",   {31'd0, done},      32'd0);
        @(negedge clk);

        // Start mid-load is ignored
        load_t2_image();
        model();
        obs_wr.delete();
        pulse_start();
        send(0, 6, 0);
        pulse_start();
        send(7, stim.size() - 1, 25);
        wait_end();
        repeat (2) @(negedge clk);
        compare("t6_midstart");

        // Start in DONE drops done and re-asserts cpu reset next cycle
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t6_restart_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("t6_restart_done",   {31'd0, done},      32'd0);
        chk("t6_restart_ready",  {31'd0, in_ready},  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
